// File: rtl/note_transcriber_pkg.sv
// Shared definitions for the note transcriber: transcript geometry,
// the slot format stored in the transcript, and the recorder FSM states.
package note_pkg;

   localparam int NUM_SLOTS = 160;
   localparam int NOTE_W    = 5;
   localparam int SLOT_W    = NOTE_W + 1;
   localparam int IDX_W     = 8;

   // One transcript slot: {valid, note_idx}; all-zero is a rest
   typedef struct packed {
      logic              valid;
      logic [NOTE_W-1:0] idx;
   } note_slot_t;

   localparam note_slot_t REST = '0;

   typedef enum logic [1:0] {IDLE, ARMED, RECORD, DONE} xcr_state_t;

   // Builds a voiced slot for the given note index
   function automatic note_slot_t voiced(input logic [NOTE_W-1:0] note);
      note_slot_t s;
      s.valid = 1'b1;
      s.idx   = note;
      return s;
   endfunction

endpackage

// File: rtl/note_transcriber_if.sv
// Control, note-strobe and transcript signals of the note transcriber.
// The master side drives control and samples; the slave side is the recorder.
interface note_transcriber_if;
   import note_pkg::*;

   logic                              start_in;
   logic                              stop_in;
   logic                              beat_tick_in;
   logic                              note_valid_in;
   logic [NOTE_W-1:0]                 note_in;
   logic [NUM_SLOTS-1:0][SLOT_W-1:0]  transcript_out;
   logic [IDX_W-1:0]                  slot_idx_out;
   logic                              busy_out;
   logic                              done_out;

   modport master (
      output start_in, stop_in, beat_tick_in, note_valid_in, note_in,
      input  transcript_out, slot_idx_out, busy_out, done_out
   );

   modport slave (
      input  start_in, stop_in, beat_tick_in, note_valid_in, note_in,
      output transcript_out, slot_idx_out, busy_out, done_out
   );

endinterface

// File: rtl/note_transcriber_slot_voter.sv
// Boyer-Moore majority voter for one beat window. The outputs already
// include the sample presented this cycle, so a sample arriving together
// with the closing tick still counts toward the window being committed.
module slot_voter
   import note_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic              clk_in,
   input  logic              rst_in_n,
   input  logic              clear_in,
   input  logic              sample_in,
   input  logic [NOTE_W-1:0] note_in,
   output logic [NOTE_W-1:0] cand_out,
   output logic [CNT_W-1:0]  cnt_out,
   output logic [CNT_W-1:0]  vcount_out
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [NOTE_W-1:0] cand_q, cand_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  vcount_q, vcount_d;

   // Window totals including this cycle's sample
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      vcount_d = vcount_q;
      if (sample_in) begin
         if (vcount_q != CNT_MAX) vcount_d = vcount_q + CNT_ONE;
         if (cnt_q == '0) begin
            cand_d = note_in;
            cnt_d  = CNT_ONE;
         end else if (note_in == cand_q) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
         end else begin
            cnt_d = cnt_q - CNT_ONE;
         end
      end
   end

   assign cand_out   = cand_d;
   assign cnt_out    = cnt_d;
   assign vcount_out = vcount_d;

   // Window state; clear wins so the next window starts empty
   always_ff @(posedge clk_in or negedge rst_in_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_in_n) begin
         cand_q   <= '0;
         cnt_q    <= '0;
         vcount_q <= '0;
      end else if (clear_in) begin
         cand_q   <= '0;
         cnt_q    <= '0;
         vcount_q <= '0;
      end else begin
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         vcount_q <= vcount_d;
      end
   end

endmodule

// File: rtl/note_transcriber.sv
// Note transcriber: records the detected-note stream into a 160-slot
// transcript, one majority-voted slot per beat window.
// Optional feature macro: TRANSCRIBER_SUSTAIN_EN -- a window with no voiced
// samples repeats a voiced previous slot instead of committing a rest.
module note_transcriber
   import note_pkg::*;
#(
   parameter int MIN_VOTES = 4,
   parameter int CNT_W     = 8
) (
   input logic               clk_in,
   input logic               rst_in_n,
   note_transcriber_if.slave bus
);

   localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NUM_SLOTS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

   xcr_state_t                  state_q;
   logic       [IDX_W-1:0]      slot_idx_q;
   note_slot_t [NUM_SLOTS-1:0]  transcript_q;
   logic                        done_q;

   logic              voter_clear;
   logic              voter_sample;
   logic [NOTE_W-1:0] cand;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  vcount;
   note_slot_t        commit_slot;

   // Samples only count while recording; any window boundary empties the voter
   assign voter_sample = bus.note_valid_in && (state_q == RECORD);
   assign voter_clear  = (state_q != RECORD) || bus.start_in || bus.beat_tick_in;

   slot_voter #(.CNT_W(CNT_W)) u_voter (
      .clk_in     (clk_in),
      .rst_in_n   (rst_in_n),
      .clear_in   (voter_clear),
      .sample_in  (voter_sample),
      .note_in    (bus.note_in),
      .cand_out   (cand),
      .cnt_out    (cnt),
      .vcount_out (vcount)
   );

`ifdef TRANSCRIBER_SUSTAIN_EN
   logic [IDX_W-1:0] prev_idx;
   note_slot_t       prev_slot;
   assign prev_idx  = (slot_idx_q == '0) ? '0 : slot_idx_q - IDX_ONE;
   assign prev_slot = transcript_q[prev_idx];
`endif

   // Value written into the slot when the current window closes
   always_comb begin
      commit_slot = REST;
      if ((vcount >= CNT_W'(MIN_VOTES)) && (cnt != '0)) begin
         commit_slot = voiced(cand);
      end
`ifdef TRANSCRIBER_SUSTAIN_EN
      else if ((vcount == '0) && (slot_idx_q != '0) && prev_slot.valid) begin
         commit_slot = prev_slot;
      end
`endif
   end

   // Recorder FSM with slot index, transcript array and done pulse
   always_ff @(posedge clk_in or negedge rst_in_n) begin
      // NOTE: the transcript array is reset as well, because the scorer reads it directly after reset.
      if (!rst_in_n) begin
         state_q      <= IDLE;
         slot_idx_q   <= '0;
         transcript_q <= '0;
         done_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.start_in) begin
            state_q      <= ARMED;
            slot_idx_q   <= '0;
            transcript_q <= '0;
         end else begin
            case (state_q)
               ARMED: begin
                  if (bus.stop_in) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else if (bus.beat_tick_in) begin
                     state_q <= RECORD;
                  end
               end
               RECORD: begin
                  if (bus.stop_in) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else if (bus.beat_tick_in) begin
                     transcript_q[slot_idx_q] <= commit_slot;
                     slot_idx_q               <= slot_idx_q + IDX_ONE;
                     if (slot_idx_q == LAST_SLOT) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.transcript_out = transcript_q;
   assign bus.slot_idx_out   = slot_idx_q;
   assign bus.busy_out       = (state_q == ARMED) || (state_q == RECORD);
   assign bus.done_out       = done_q;

endmodule
